adc_scan_ctrl: RTL
==================

Name: adc_scan_ctrl

Overview:
- Parametrised multi-channel scan controller for AD7829-class parallel-output ADCs: sequences CONVST/EOC/CS/RD per channel and writes tagged samples into the capture RAM.
- Adds configurable timing, a channel mask, single/continuous scan modes, a wrapping RAM write pointer and frame-done signalling.
- Sits between the ADC pins and the dual-port capture RAM.

Parameters:
- DATA_W, 8, ADC data width.
- NUM_CH, 8, physical channels, 1..8.
- CH_AW, 3, ADC address width, >= clog2(NUM_CH).
- MEM_AW, 10, RAM write-address width; depth is 2**MEM_AW.
- CONVST_CYC, 3, CONVST low-pulse length in clk cycles (>=50 ns).
- RD_CYC, 2, CS/RD low time before data latch.
- QUIET_CYC, 2, idle gap after RD rises (>=30 ns).
- TIMEOUT_CYC, 255, EOC wait limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- start  in  1  pulse: begin a scan.
- stop  in  1  pulse: end continuous mode after the current frame.
- continuous  in  1  sampled at start; 1 = repeat frames.
- ch_mask  in  NUM_CH  enabled channels, latched at each frame start.
- adc_data  in  DATA_W  ADC parallel bus.
- adc_eoc  in  1  ADC end-of-conversion, async, active-low.
- adc_convst_n / adc_cs_n / adc_rd_n  out  1 each  ADC strobes, active-low.
- adc_addr  out  CH_AW  ADC channel address.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  MEM_AW  RAM write address.
- wr_data  out  DATA_W  sample.
- wr_ch  out  CH_AW  channel tag for the sample.
- busy  out  1  scan in progress.
- frame_done  out  1  one-cycle pulse after the last enabled channel of a frame.
- timeout  out  1  sticky EOC-timeout flag (optional feature).

Behaviour:
- Reset, asynchronous: convst_n=cs_n=rd_n=1; adc_addr=0; wr_en=0; wr_addr=0; wr_data=0; wr_ch=0; busy=0; frame_done=0; timeout=0; FSM to IDLE. Reset asserted mid-conversion releases all strobes immediately.
- adc_eoc passes through a 2-flop synchroniser. A falling edge is detected on the synchronised value.
- FSM states: IDLE, CONV, WAIT_EOC, CS_SETUP, READ, WRITE, QUIET.
- IDLE:
  - On start with ch_mask!=0: latch mask and mode, set busy=1, adc_addr = lowest enabled channel, go to CONV.
  - start with ch_mask==0 is ignored.
- CONV: convst_n=0 for exactly CONVST_CYC cycles, then WAIT_EOC.
- WAIT_EOC: on the synchronised EOC falling edge, go to CS_SETUP.
- CS_SETUP: cs_n=0 for 1 cycle. Compute the next enabled channel, wrapping from the highest back to the lowest in the mask. Drive it on adc_addr, but hold the current channel in an internal tag register.
- READ: cs_n=0, rd_n=0 for RD_CYC cycles. adc_data is latched on the last READ cycle.
- WRITE:
  - rd_n=1, cs_n=1, wr_en=1 for one cycle with the latched data and tag; wr_addr increments after the write, wrapping 2**MEM_AW-1 to 0.
  - Sample-to-RAM latency is RD_CYC+1 cycles from rd_n falling.
- QUIET: all strobes high for QUIET_CYC cycles, then:
  - Frame not finished: go to CONV.
  - Frame finished: pulse frame_done.
    - continuous=1 and no stop seen: re-latch ch_mask, go to CONV.
    - Otherwise: busy=0, go to IDLE.
- stop may arrive in any state. It is remembered and only takes effect at the end of the frame. stop in IDLE is ignored.
- start while busy is ignored.
- A single-channel mask samples the same channel repeatedly; adc_addr stays constant.
- frame_done and wr_en can coincide only in the sense that frame_done fires in the last QUIET cycle, never in WRITE.
- wr_addr is not cleared between scans; only reset clears it.

Optional Feature:
- Macro ADC_SCAN_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_EOC. Reaching TIMEOUT_CYC sets timeout=1 (sticky until reset or the next start).
  - All strobes release, no write occurs, busy=0, and the FSM returns to IDLE.
- Not defined: WAIT_EOC waits indefinitely, and timeout is tied to 0.

Test Plan:
- Reset then idle: all strobes 1, busy 0, wr_addr 0. A start with ch_mask=0 leaves busy at 0.
- Single scan, ch_mask=8'b1010_0101, ADC model with EOC 20 cycles after CONVST, data=0x40+ch:
  - Exactly 4 writes with wr_ch 0,2,5,7 and data 0x40,0x42,0x45,0x47.
  - One frame_done, then busy=0.
- Strobe timing check: convst_n low exactly 3 cycles; rd_n low exactly 2 cycles; at least 2 idle cycles between rd_n rising and the next convst_n falling.
- Continuous mode, MEM_AW=3, ch_mask=0x03, stop issued mid-frame 5:
  - The 8th write lands at address 7 and the 9th at address 0.
  - Scan halts after frame 5 completes (10 writes total).
- Reset asserted during READ: rd_n and cs_n go high the same cycle, with no write.
- With ADC_SCAN_TIMEOUT_EN and EOC never falling:
  - timeout=1 after 255 WAIT_EOC cycles, busy=0, no wr_en.
  - The next start clears timeout.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel scan controller for AD7829-class parallel-output ADCs.
// Sequences CONVST/EOC/CS/RD for every enabled channel of a mask, tags each sample
// with its channel and writes it into the capture RAM through a wrapping write pointer.
// Optional feature: define ADC_SCAN_TIMEOUT_EN to abort a scan when EOC never arrives
// within TIMEOUT_CYC cycles (sticky timeout flag). Without it, timeout is tied to 0.
module adc_scan_ctrl #(
   parameter int DATA_W      = 8,
   parameter int NUM_CH      = 8,
   parameter int CH_AW       = 3,
   parameter int MEM_AW      = 10,
   parameter int CONVST_CYC  = 3,
   parameter int RD_CYC      = 2,
   parameter int QUIET_CYC   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_eoc,
   output logic              adc_convst_n,
   output logic              adc_cs_n,
   output logic              adc_rd_n,
   output logic [CH_AW-1:0]  adc_addr,
   output logic              wr_en,
   output logic [MEM_AW-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [CH_AW-1:0]  wr_ch,
   output logic              busy,
   output logic              frame_done,
   output logic              timeout
);

   typedef enum logic [2:0] {
      IDLE, CONV, WAIT_EOC, CS_SETUP, READ, WRITE, QUIET
   } state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared phase counter covers every timed state, so it is sized for the longest.
   localparam int CNT_MAX = max_of(max_of(CONVST_CYC, RD_CYC), max_of(QUIET_CYC, TIMEOUT_CYC));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONVST_CYC - 1);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(RD_CYC - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);

   // Lowest enabled channel of a mask (0 for an empty mask, which is never scanned).
   function automatic logic [CH_AW-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
      logic [CH_AW-1:0] ch;
      ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i]) ch = CH_AW'(i);
      return ch;
   endfunction

   // Next enabled channel above cur, wrapping to the lowest enabled one.
   function automatic logic [CH_AW-1:0] next_ch(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_AW-1:0]  cur);
      logic [CH_AW-1:0] ch;
      ch = lowest_ch(mask);
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i] && (i > int'(cur))) ch = CH_AW'(i);
      return ch;
   endfunction

   // True when no enabled channel lies above cur, i.e. cur closes the frame.
   function automatic logic is_last_ch(input logic [NUM_CH-1:0] mask,
                                       input logic [CH_AW-1:0]  cur);
      logic last;
      last = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (mask[i] && (i > int'(cur))) last = 1'b0;
      return last;
   endfunction

   state_t            state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic              eoc_meta, eoc_sync, eoc_prev;
   logic              eoc_fall;
   logic [NUM_CH-1:0] mask_q;
   logic              cont_q;
   logic              stop_q;
   logic [CH_AW-1:0]  tag_q;
   logic              frame_last;
   logic              conv_done, read_done, quiet_done;
   logic              frame_end;
   logic              rerun;

   assign eoc_fall   = eoc_prev & ~eoc_sync;
   assign conv_done  = (cnt == CONV_LAST);
   assign read_done  = (cnt == READ_LAST);
   assign quiet_done = (cnt == QUIET_LAST);
   assign frame_end  = (state == QUIET) && quiet_done && frame_last;
   // A stop arriving in the very last QUIET cycle still ends the scan.
   assign rerun      = cont_q && !(stop_q || stop) && (ch_mask != '0);
   assign frame_done = frame_end;

`ifdef ADC_SCAN_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic wait_expired;
   assign wait_expired = (cnt == TIMEOUT_LAST);

   // Sticky EOC-timeout flag, cleared only by reset or an accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         timeout <= 1'b0;
      else if ((state == IDLE) && (next_state == CONV))
         timeout <= 1'b0;
      else if ((state == WAIT_EOC) && (next_state == IDLE))
         timeout <= 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   // Two-flop synchroniser on the asynchronous EOC pin plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
      if (!reset_n) begin
         eoc_meta <= 1'b1;
         eoc_sync <= 1'b1;
         eoc_prev <= 1'b1;
      end else begin
         eoc_meta <= adc_eoc;
         eoc_sync <= eoc_meta;
         eoc_prev <= eoc_sync;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Phase counter: restarts on every state change, idles in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 cnt <= '0;
      else if (next_state != state) cnt <= '0;
      else if (state != IDLE)       cnt <= cnt + 1'b1;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      unique case (state)
         IDLE:     if (start && (ch_mask != '0)) next_state = CONV;
         CONV:     if (conv_done) next_state = WAIT_EOC;
         WAIT_EOC:
            if (eoc_fall) next_state = CS_SETUP;
`ifdef ADC_SCAN_TIMEOUT_EN
            else if (wait_expired) next_state = IDLE;
`endif
         CS_SETUP: next_state = READ;
         READ:     if (read_done) next_state = WRITE;
         WRITE:    next_state = QUIET;
         QUIET:
            if (quiet_done) begin
               if (!frame_last || rerun) next_state = CONV;
               else                      next_state = IDLE;
            end
         default:  next_state = IDLE;
      endcase
   end

   // Pin strobes and status, registered from the next state so they change cleanly on the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         adc_convst_n <= 1'b1;
         adc_cs_n     <= 1'b1;
         adc_rd_n     <= 1'b1;
         wr_en        <= 1'b0;
         busy         <= 1'b0;
      end else begin
         adc_convst_n <= (next_state != CONV);
         adc_cs_n     <= (next_state != CS_SETUP) && (next_state != READ);
         adc_rd_n     <= (next_state != READ);
         wr_en        <= (next_state == WRITE);
         busy         <= (next_state != IDLE);
      end
   end

   // Scan context: mask/mode/stop latches, ADC channel pointer and the tag of the sample in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         cont_q     <= 1'b0;
         stop_q     <= 1'b0;
         adc_addr   <= '0;
         tag_q      <= '0;
         frame_last <= 1'b0;
      end else begin
         if (state == IDLE) begin
            stop_q <= 1'b0;
            if (next_state == CONV) begin
               mask_q   <= ch_mask;
               cont_q   <= continuous;
               adc_addr <= lowest_ch(ch_mask);
            end
         end else if (stop) begin
            stop_q <= 1'b1;
         end
         // The ADC address moves on during the read; the converted channel stays in tag_q.
         if (state == CS_SETUP) begin
            tag_q      <= adc_addr;
            adc_addr   <= next_ch(mask_q, adc_addr);
            frame_last <= is_last_ch(mask_q, adc_addr);
         end
         if (frame_end && (next_state == CONV)) begin
            mask_q   <= ch_mask;
            adc_addr <= lowest_ch(ch_mask);
         end
      end
   end

   // Sample capture on the last READ cycle and wrapping RAM write pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_data <= '0;
         wr_ch   <= '0;
         wr_addr <= '0;
      end else begin
         if ((state == READ) && read_done) begin
            wr_data <= adc_data;
            wr_ch   <= tag_q;
         end
         if (state == WRITE) wr_addr <= wr_addr + 1'b1;
      end
   end

endmodule
